// File: rtl/load_store_unit.sv
// Load/store unit: memory stage behind the ALU. Accepts one load or store
// request at a time and issues a single word-addressed memory access with
// byte enables and a req/ack handshake. Load data is aligned and sign- or
// zero-extended for writeback. A bounded ack timeout turns a stuck access
// into an error response.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses
// are reported as errors instead of being forced to natural alignment).
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Last ACCESS cycle before the wait is abandoned.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        st_q, st_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  a_q, a_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        resp_err_q, resp_err_d;
  logic        legal, misalign;

  function automatic logic is_legal(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Size lives in funct3[1:0]; halfword lane uses a[1] only, word uses none.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] rd);
    logic [31:0] b, h;
    b = rd >> {a, 3'b000};
    h = rd >> {a[1], 4'b0000};
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b100:  return {24'h0, b[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b101:  return {16'h0, h[15:0]};
      default: return rd;
    endcase
  endfunction

  // Classify the incoming request: legality and (optionally) alignment.
  always_comb begin
    legal = is_legal(is_store, funct3);
`ifdef MISALIGN_TRAP_EN
    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  // Next-state and registered-output logic for IDLE -> ACCESS -> RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    f3_d        = f3_q;
    a_d         = a_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          st_d = is_store;
          f3_d = funct3;
          a_d  = addr[1:0];
          if (!legal || misalign) begin
            state_d     = RESP;
            resp_err_d  = 1'b1;
            load_data_d = 32'h0;
          end else begin
            state_d     = ACCESS;
            cnt_d       = 8'h0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = lane_mask(funct3, addr[1:0]);
            mem_wdata_d = is_store ? lane_data(funct3, store_data) : 32'h0;
          end
        end
      end
      ACCESS: begin
        // Ack wins over the timeout when both land in the same cycle.
        if (mem_ack) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'h0;
          resp_err_d  = 1'b0;
          load_data_d = st_q ? 32'h0 : extract(f3_q, a_q, mem_rdata);
        end else if (cnt_q == LIMIT) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'h0;
          resp_err_d  = 1'b1;
          load_data_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset also aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'h0;
      st_q        <= 1'b0;
      f3_q        <= 3'h0;
      a_q         <= 2'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      load_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      f3_q        <= f3_d;
      a_q         <= a_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_data  = load_data_q;
  assign resp_err   = resp_err_q;

endmodule
